temp_sample_sequencer: RTL and testbench
========================================

// Module: temp_sample_sequencer
// PURPOSE
//  Periodic sampling controller for the on-board temperature sensor reader. Issues
//  start pulses on a fixed period and waits for each sample with a timeout.
//  Accumulates and averages 2**AVG_LOG2 samples, then drives a hysteresis over-temp
//  alarm. Sits between the sensor reader and the SoC register/IRQ logic.
// PARAMETERS
//  CLK_DIV   1_000_000  sample period in clk cycles (start-to-start), >=4
//  TIMEOUT   4096       max cycles from sensor_start to sensor_valid, >=2
//  AVG_LOG2  2          log2 of samples averaged per report (0..4)
//  TEMP_W    12         signed temperature width
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset
//  enable       in   1       1 = sampling active
//  sensor_start out  1       one-cycle request pulse to sensor reader
//  sensor_valid in   1       sample-ready strobe from sensor reader
//  sensor_temp  in   TEMP_W  signed sample, qualified by sensor_valid
//  thr_high     in   TEMP_W  signed alarm set threshold
//  thr_low      in   TEMP_W  signed alarm clear threshold
//  err_clr      in   1       clears timeout_err and overrun
//  avg_temp     out  TEMP_W  signed last reported average
//  avg_valid    out  1       one-cycle strobe, avg_temp updated
//  alarm        out  1       hysteresis over-temp flag
//  timeout_err  out  1       sticky: a request timed out
//  overrun      out  1       sticky: a period tick was dropped
//  busy         out  1       1 while in REQ or WAIT_DATA
// BEHAVIOUR
//  Reset: rst synchronous, active-high. All outputs 0; avg_temp=0; FSM=IDLE; counters/acc=0.
//  FSM: IDLE -> WAIT (enable=1); WAIT -> REQ on period tick; REQ (sensor_start=1, one
//   cycle) -> WAIT_DATA; WAIT_DATA -> UPDATE on sensor_valid, -> WAIT on timeout;
//   UPDATE -> REPORT if sample count reaches 2**AVG_LOG2, else WAIT; REPORT -> WAIT.
//  Period counter: free-running 0..CLK_DIV-1 while enable=1, cleared in IDLE; tick at
//   CLK_DIV-1. First tick CLK_DIV cycles after leaving IDLE. Tick when FSM not in WAIT
//   is dropped and sets overrun. Ticks are never queued.
//  WAIT_DATA: timeout counter starts at 0 on the cycle after REQ. sensor_valid accepted
//   only in WAIT_DATA; valid elsewhere (including the REQ cycle) is ignored. Counter
//   reaching TIMEOUT-1 without valid -> timeout_err=1. Sample discarded, acc/count kept.
//   valid on the same cycle as the timeout counter reaching TIMEOUT-1 is accepted; no error.
//  Arithmetic: acc is signed TEMP_W+AVG_LOG2 bits, sign-extended add, no saturation.
//   Average = acc >>> AVG_LOG2 (arithmetic shift, rounds toward -inf), truncated to TEMP_W.
//  REPORT: avg_temp registered, avg_valid=1 for one cycle, acc/count cleared.
//   alarm: set if avg>thr_high (signed); else cleared if avg<thr_low; else held.
//   Alarm updates in the same cycle as avg_valid. If thr_low>thr_high, the set rule wins.
//  Sticky flags: err_clr clears both. A set event in the same cycle as err_clr wins (flag=1).
//  enable=0 in any state -> IDLE next cycle, in-flight request abandoned, acc/count cleared.
//   avg_temp, alarm and sticky flags are held. Late sensor_valid is ignored.
//  busy=1 exactly in REQ and WAIT_DATA.
// CONFIGURATION
//  TEMP_SEQ_STATS_EN defined: adds outputs min_temp/max_temp (TEMP_W, signed).
//   These track the raw accepted samples since reset or err_clr. On reset they are 0
//   and the first sample loads both.
//  Undefined: those ports and their registers are absent; all other behaviour is identical.
// TESTING (CLK_DIV=16, TIMEOUT=8, AVG_LOG2=2)
//  Samples 20,21,22,23 with valid 3 cycles after each start -> one avg_valid, avg_temp=21.
//   Starts are spaced exactly 16 cycles apart.
//  Samples -1,-2,-2,-2 -> sum -7, avg_temp=-2.
//  thr_high=25, thr_low=20: averages 26, 22, 19 -> alarm 1, 1, 0.
//  No valid after a start -> timeout_err=1, 8 cycles after the REQ cycle. Count unchanged,
//   next start at the next tick. err_clr -> timeout_err=0.
//  Valid held off 20 cycles -> timeout fires first; the tick during WAIT_DATA sets overrun.
//  enable dropped in WAIT_DATA -> IDLE, busy=0, late valid ignored, avg_temp held.
//   Re-enable -> first start after 16 cycles.

Source files
------------

// File: rtl/temp_sample_sequencer.sv
// Periodic temperature sampler: timed sensor requests, block averaging and hysteresis alarm.
// Define TEMP_SEQ_STATS_EN to add min_temp/max_temp tracking of accepted raw samples.
module temp_sample_sequencer #(
  parameter int unsigned CLK_DIV  = 1_000_000,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TEMP_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic                     sensor_start,
  input  logic                     sensor_valid,
  input  logic signed [TEMP_W-1:0] sensor_temp,
  input  logic signed [TEMP_W-1:0] thr_high,
  input  logic signed [TEMP_W-1:0] thr_low,
  input  logic                     err_clr,
  output logic signed [TEMP_W-1:0] avg_temp,
  output logic                     avg_valid,
  output logic                     alarm,
  output logic                     timeout_err,
  output logic                     overrun,
`ifdef TEMP_SEQ_STATS_EN
  output logic signed [TEMP_W-1:0] min_temp,
  output logic signed [TEMP_W-1:0] max_temp,
`endif
  output logic                     busy
);

  localparam int unsigned PerW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT);
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam int unsigned AccW = TEMP_W + AVG_LOG2;
  localparam logic [PerW-1:0] PerLast = PerW'(CLK_DIV - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] NSamp   = CntW'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {StIdle, StWait, StReq, StWaitData, StUpdate, StReport} state_e;

  state_e                   state_q, state_d;
  logic [PerW-1:0]          per_q, per_d;
  logic [ToW-1:0]           to_q, to_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [TEMP_W-1:0] avg_q, avg_d;
  logic                     alarm_q, alarm_d;
  logic                     terr_q, terr_d;
  logic                     ovr_q, ovr_d;

  logic                     tick, accept, tmo;
  logic signed [AccW-1:0]   acc_sum;
  logic signed [TEMP_W-1:0] avg_new;

  assign tick    = enable && (state_q != StIdle) && (per_q == PerLast);
  assign accept  = enable && (state_q == StWaitData) && sensor_valid;
  assign tmo     = enable && (state_q == StWaitData) && !sensor_valid && (to_q == ToLast);
  assign acc_sum = acc_q + AccW'(sensor_temp);
  // Arithmetic shift floors toward -inf; the result is truncated to the sample width.
  assign avg_new = TEMP_W'(acc_q >>> AVG_LOG2);

  always_comb begin
    state_d = state_q;
    per_d   = '0;
    to_d    = '0;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    avg_d   = avg_q;
    alarm_d = alarm_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StWait;
      StWait:   if (tick) state_d = StReq;
      StReq:    state_d = StWaitData;
      StWaitData: begin
        to_d = to_q + 1'b1;
        if (sensor_valid) begin
          acc_d   = acc_sum;
          cnt_d   = cnt_q + 1'b1;
          state_d = StUpdate;
        end else if (to_q == ToLast) begin
          state_d = StWait;
        end
      end
      StUpdate: begin
        if (cnt_q == NSamp) begin
          state_d = StReport;
          avg_d   = avg_new;
          // Set rule is checked first so it wins when the thresholds are inverted.
          if (avg_new > thr_high) alarm_d = 1'b1;
          else if (avg_new < thr_low) alarm_d = 1'b0;
        end else begin
          state_d = StWait;
        end
      end
      StReport: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StWait;
      end
      default:  state_d = StIdle;
    endcase

    if (state_q != StIdle && enable && per_q != PerLast) per_d = per_q + 1'b1;

    // Disabling abandons any request and partial average; reported values are kept.
    if (!enable) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      avg_d   = avg_q;
      alarm_d = alarm_q;
    end

    terr_d = tmo | (terr_q & ~err_clr);
    ovr_d  = (tick && state_q != StWait) | (ovr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      per_q   <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
      alarm_q <= 1'b0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      alarm_q <= alarm_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef TEMP_SEQ_STATS_EN
  logic                     seen_q;
  logic signed [TEMP_W-1:0] min_q, max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= 1'b0;
      min_q  <= '0;
      max_q  <= '0;
    end else if (accept && (err_clr || !seen_q)) begin
      seen_q <= 1'b1;
      min_q  <= sensor_temp;
      max_q  <= sensor_temp;
    end else if (err_clr) begin
      seen_q <= 1'b0;
      min_q  <= '0;
      max_q  <= '0;
    end else if (accept) begin
      if (sensor_temp < min_q) min_q <= sensor_temp;
      if (sensor_temp > max_q) max_q <= sensor_temp;
    end
  end

  assign min_temp = min_q;
  assign max_temp = max_q;
`endif

  assign sensor_start = (state_q == StReq);
  assign busy         = (state_q == StReq) || (state_q == StWaitData);
  assign avg_valid    = (state_q == StReport);
  assign avg_temp     = avg_q;
  assign alarm        = alarm_q;
  assign timeout_err  = terr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// Bench for temp_sample_sequencer: timestamp-based reference model checked every cycle,
// directed sample/timeout/disable scenarios, and a second instance for the overrun case.
`timescale 1ns/1ps
module tb_temp_sample_sequencer;
  localparam int CLK_DIV  = 16;
  localparam int TIMEOUT  = 8;
  localparam int AVG_LOG2 = 2;
  localparam int TEMP_W   = 12;
  localparam int NSAMP    = 1 << AVG_LOG2;
  localparam int NEVER    = 32'h3fff_ffff;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sensor_valid = 1'b0, err_clr = 1'b0;
  logic signed [TEMP_W-1:0] sensor_temp = '0;
  logic signed [TEMP_W-1:0] thr_high = 12'sd25, thr_low = 12'sd20;
  logic sensor_start, avg_valid, alarm, timeout_err, overrun, busy;
  logic signed [TEMP_W-1:0] avg_temp;

  logic o_enable = 1'b0, o_valid = 1'b0, o_clr = 1'b0;
  logic signed [TEMP_W-1:0] o_temp = 12'sd7;
  logic o_start, o_avg_valid, o_alarm, o_terr, o_ovr, o_busy;
  logic signed [TEMP_W-1:0] o_avg;
`ifdef TEMP_SEQ_STATS_EN
  logic signed [TEMP_W-1:0] min_temp, max_temp, o_min, o_max;
`endif

  always #5 clk = ~clk;

  temp_sample_sequencer #(
    .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2), .TEMP_W(TEMP_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor_start(sensor_start),
    .sensor_valid(sensor_valid), .sensor_temp(sensor_temp), .thr_high(thr_high),
    .thr_low(thr_low), .err_clr(err_clr), .avg_temp(avg_temp), .avg_valid(avg_valid),
    .alarm(alarm), .timeout_err(timeout_err), .overrun(overrun),
`ifdef TEMP_SEQ_STATS_EN
    .min_temp(min_temp), .max_temp(max_temp),
`endif
    .busy(busy)
  );

  // Short period with a long timeout, so a tick always lands inside WAIT_DATA.
  temp_sample_sequencer #(
    .CLK_DIV(8), .TIMEOUT(16), .AVG_LOG2(0), .TEMP_W(TEMP_W)
  ) u_ovr (
    .clk(clk), .rst(rst), .enable(o_enable), .sensor_start(o_start),
    .sensor_valid(o_valid), .sensor_temp(o_temp), .thr_high(thr_high),
    .thr_low(thr_low), .err_clr(o_clr), .avg_temp(o_avg), .avg_valid(o_avg_valid),
    .alarm(o_alarm), .timeout_err(o_terr), .overrun(o_ovr),
`ifdef TEMP_SEQ_STATS_EN
    .min_temp(o_min), .max_temp(o_max),
`endif
    .busy(o_busy)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  bit model_ok = 1'b0;
  int o_avg_seen = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: timestamps of the next request, the accepting window and when the sequencer is
  // free to take a tick again; samples kept in a queue and averaged with floor division.
  bit m_active = 1'b0, m_win = 1'b0, m_seen = 1'b0;
  int m_go = 0, m_req = -1, m_free = NEVER, m_rep = -1;
  int q[$];
  logic e_start, e_busy, e_avg_valid, e_alarm, e_terr, e_ovr;
  int e_avg, e_min, e_max;

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / NSAMP;
    return -((-s + NSAMP - 1) / NSAMP);
  endfunction

  task automatic model_step();
    bit in_wait, tick, set_t, set_o, got;
    int sum, samp;
    set_t = 1'b0; set_o = 1'b0; got = 1'b0; samp = 0;
    if (rst) begin
      m_active = 1'b0; m_win = 1'b0; m_req = -1; m_rep = -1; q.delete();
      e_avg = 0; e_alarm = 1'b0; e_terr = 1'b0; e_ovr = 1'b0; e_avg_valid = 1'b0;
      m_seen = 1'b0; e_min = 0; e_max = 0; model_ok = 1'b1;
    end else begin
      e_avg_valid = 1'b0;
      if (!m_active) begin
        if (enable) begin
          m_active = 1'b1; m_go = cyc + 1; m_free = cyc + 1; m_req = -1; m_win = 1'b0;
        end
      end else if (!enable) begin
        m_active = 1'b0; m_win = 1'b0; m_req = -1; m_rep = -1; q.delete();
      end else begin
        in_wait = cyc >= m_free;
        tick = ((cyc - m_go) % CLK_DIV) == CLK_DIV - 1;
        if (tick && in_wait) begin m_req = cyc + 1; m_free = NEVER; end
        else if (tick) set_o = 1'b1;
        if (m_win) begin
          if (sensor_valid) begin
            m_win = 1'b0; got = 1'b1; samp = int'(sensor_temp); q.push_back(samp);
            if (q.size() == NSAMP) begin m_rep = cyc + 2; m_free = cyc + 3; end
            else m_free = cyc + 2;
          end else if (cyc == m_req + TIMEOUT) begin
            m_win = 1'b0; set_t = 1'b1; m_free = cyc + 1;
          end
        end else if (cyc == m_req) begin
          m_win = 1'b1;
        end
        if (m_rep == cyc + 1) begin
          sum = 0;
          foreach (q[i]) sum += q[i];
          e_avg = floor_avg(sum);
          if (e_avg > int'(thr_high)) e_alarm = 1'b1;
          else if (e_avg < int'(thr_low)) e_alarm = 1'b0;
          e_avg_valid = 1'b1; q.delete(); m_rep = -1;
        end
      end
      if (got && (!m_seen || err_clr)) begin e_min = samp; e_max = samp; m_seen = 1'b1; end
      else if (err_clr) begin e_min = 0; e_max = 0; m_seen = 1'b0; end
      else if (got) begin
        if (samp < e_min) e_min = samp;
        if (samp > e_max) e_max = samp;
      end
      e_terr = set_t | (e_terr & !err_clr);
      e_ovr  = set_o | (e_ovr & !err_clr);
    end
    e_start = m_active && (m_req == cyc + 1);
    e_busy  = m_active && (e_start || m_win);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (o_avg_valid === 1'b1) o_avg_seen++;
    if (model_ok) begin
      chk("sensor_start", sensor_start, e_start);
      chk("busy", busy, e_busy);
      chk("avg_valid", avg_valid, e_avg_valid);
      chk("avg_temp", avg_temp, e_avg);
      chk("alarm", alarm, e_alarm);
      chk("timeout_err", timeout_err, e_terr);
      chk("overrun", overrun, e_ovr);
`ifdef TEMP_SEQ_STATS_EN
      chk("min_temp", min_temp, e_min);
      chk("max_temp", max_temp, e_max);
`endif
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int starts[$];

  task automatic wait_start(output int at);
    at = -1;
    for (int k = 0; k < 4 * CLK_DIV && at < 0; k++) begin
      if (sensor_start === 1'b1) at = cyc;
      else step();
    end
    if (at < 0) chk("wait_start_bound", 0, 1);
    starts.push_back(at);
  endtask

  task automatic respond(input int delay, input int temp);
    int r;
    wait_start(r);
    step(delay);
    sensor_temp = TEMP_W'(temp);
    sensor_valid = 1'b1;
    step();
    sensor_valid = 1'b0;
  endtask

  task automatic wait_avg();
    bit seen = 1'b0;
    for (int k = 0; k < 3 * CLK_DIV && !seen; k++) begin
      if (avg_valid === 1'b1) seen = 1'b1;
      else step();
    end
    if (!seen) chk("wait_avg_bound", 0, 1);
  endtask

  task automatic group4(input int a, input int b, input int c, input int d);
    respond(3, a); respond(3, b); respond(3, c); respond(3, d);
    wait_avg();
  endtask

  initial begin
    int r, en_cyc, ro;
    bit found;
    step(3);
    rst = 1'b0;
    chk("rst_sensor_start", sensor_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_temp", avg_temp, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overrun", overrun, 0);

    enable = 1'b1; en_cyc = cyc;
    group4(20, 21, 22, 23);
    chk("first_start_latency", starts[0] - en_cyc, CLK_DIV + 1);
    chk("start_spacing", starts[1] - starts[0], CLK_DIV);
    chk("avg_20_23", avg_temp, 21);
    chk("alarm_21", alarm, 0);

    group4(-1, -2, -2, -2);
    chk("avg_neg", avg_temp, -2);

    group4(26, 26, 26, 26);
    chk("alarm_26", alarm, 1);
    group4(22, 22, 22, 22);
    chk("alarm_22_held", alarm, 1);
    group4(19, 19, 19, 19);
    chk("alarm_19", alarm, 0);

    // Timeout mid-group: accumulated samples survive.
    respond(3, 10); respond(3, 10);
    wait_start(r);
    step(TIMEOUT);
    chk("terr_before", timeout_err, 0);
    step();
    chk("terr_after", timeout_err, 1);
    respond(3, 14);
    chk("start_after_timeout", starts[starts.size() - 1] - r, CLK_DIV);
    respond(3, 14);
    wait_avg();
    chk("avg_across_timeout", avg_temp, 12);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("terr_cleared", timeout_err, 0);

    // Disable mid-request: partial sum dropped, late valid ignored, average held.
    respond(3, 100);
    wait_start(r);
    step(2);
    enable = 1'b0;
    step();
    chk("busy_after_disable", busy, 0);
    sensor_temp = 12'sd5; sensor_valid = 1'b1; step(); sensor_valid = 1'b0;
    chk("avg_held", avg_temp, 12);
    step(3);
    enable = 1'b1; en_cyc = cyc;
    r = starts.size();
    group4(0, 0, 0, 4);
    chk("reenable_latency", starts[r] - en_cyc, CLK_DIV + 1);
    chk("avg_after_reenable", avg_temp, 1);

    // Overrun instance: valid held off 20 cycles after its first start.
    o_enable = 1'b1;
    found = 1'b0; ro = -1;
    for (int k = 0; k < 40 && !found; k++) begin
      if (o_start === 1'b1) begin found = 1'b1; ro = cyc; end
      else step();
    end
    if (!found) chk("o_wait_start_bound", 0, 1);
    step(6);
    chk("o_ovr_before_tick", o_ovr, 0);
    step(2);
    chk("o_ovr_tick_in_wait_data", o_ovr, 1);
    chk("o_terr_early", o_terr, 0);
    step(8);
    chk("o_terr_before", o_terr, 0);
    step();
    chk("o_terr_after", o_terr, 1);
    step(3);
    chk("o_valid_at_20", cyc - ro, 20);
    o_valid = 1'b1; step(); o_valid = 1'b0;
    step(5);
    chk("o_late_valid_ignored", o_avg_seen, 0);
    chk("o_avg_untouched", o_avg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
